mem_bus_ctrl: RTL

Downstream consumer of the picorv32 native memory bus: decodes each CPU request and routes it to one of four regions.
- RAM: external sync BRAM/SPRAM port.
- ROM: program memory port.
- IO: on-chip LED, UART TX and cycle counter registers.
- Unmapped: everything else.

Generates cpu_mem_rdy and cpu_di back to the core. Sits between the CPU wrapper and the memory macros in the top level.

---
 rtl/mem_map_pkg.sv | 31 +++
 rtl/uart_tx_8n1.sv | 59 +++++
 rtl/mem_bus_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared memory-map definitions for the CPU bus controller.
//   - default region base addresses (RAM, ROM, IO)
//   - IO register byte offsets within the 16-byte IO window
//   - region select enum and bus-controller FSM state enum
package mem_map_pkg;

  localparam logic [31:0] MM_RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] MM_ROM_BASE = 32'h0002_0000;
  localparam logic [31:0] MM_IO_BASE  = 32'h0003_0000;
  localparam logic [31:0] MM_IO_SIZE  = 32'd16;

  // Byte offsets of the IO registers relative to the IO base.
  localparam logic [3:0] IO_LED    = 4'h0;
  localparam logic [3:0] IO_UART   = 4'h4;
  localparam logic [3:0] IO_STATUS = 4'h8;
  localparam logic [3:0] IO_CYCLES = 4'hC;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_ROM,
    REG_IO,
    REG_NONE
  } region_e;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    UART_STALL
  } state_e;

endpackage

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: 8N1 serial transmitter, LSB first, CLK_DIV clocks per bit.
//   clk   - system clock
//   reset - asynchronous active-low reset (forces tx high, idle)
//   load  - one-cycle strobe: start sending data (ignored while busy)
//   data  - byte to send, sampled on load
//   busy  - high from the load edge until the stop bit has completed
//   tx    - serial output, idle high
module uart_tx_8n1 #(
  parameter int CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int DW = $clog2(CLK_DIV + 1);

  logic [DW-1:0] div_reg;
  logic [8:0]    shift_reg;   // remaining bits: data LSB first, then stop bit
  logic [3:0]    left_reg;    // bits still to be shifted out after the current one
  logic          busy_reg;
  logic          tx_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg   <= '0;
      shift_reg <= '1;
      left_reg  <= '0;
      busy_reg  <= 1'b0;
      tx_reg    <= 1'b1;
    end else if (load && !busy_reg) begin
      // Start bit goes out immediately; the rest waits in the shifter.
      tx_reg    <= 1'b0;
      shift_reg <= {1'b1, data};
      left_reg  <= 4'd9;
      div_reg   <= DW'(CLK_DIV - 1);
      busy_reg  <= 1'b1;
    end else if (busy_reg) begin
      if (div_reg != '0) begin
        div_reg <= div_reg - 1'b1;
      end else if (left_reg != '0) begin
        tx_reg    <= shift_reg[0];
        shift_reg <= {1'b1, shift_reg[8:1]};
        left_reg  <= left_reg - 1'b1;
        div_reg   <= DW'(CLK_DIV - 1);
      end else begin
        // Stop bit has lasted its full period; tx is already high.
        busy_reg <= 1'b0;
      end
    end
  end

  assign busy = busy_reg;
  assign tx   = tx_reg;

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: picorv32 native-bus consumer. Decodes each request into
// RAM, ROM, IO or unmapped space and returns cpu_mem_rdy/cpu_di.
//   clk, reset          - clock, asynchronous active-low reset
//   cpu_mem_op/rdy      - request valid (held) / one-cycle completion pulse
//   cpu_adr/do/wren/di  - byte address, write data, byte strobes, read data
//   ram_*               - sync RAM port (read data one cycle after ram_en)
//   rom_*               - sync ROM port (read data one cycle after rom_en)
//   led, uart_tx        - IO outputs
module mem_bus_ctrl
  import mem_map_pkg::*;
#(
  parameter logic [31:0] RAM_BASE = MM_RAM_BASE,
  parameter int          RAM_AW   = 14,
  parameter logic [31:0] ROM_BASE = MM_ROM_BASE,
  parameter int          ROM_AW   = 14,
  parameter logic [31:0] IO_BASE  = MM_IO_BASE,
  parameter int          CLK_DIV  = 104
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mem_op,
  output logic              cpu_mem_rdy,
  input  logic [31:0]       cpu_adr,
  input  logic [31:0]       cpu_do,
  input  logic [3:0]        cpu_wren,
  output logic [31:0]       cpu_di,
  output logic              ram_en,
  output logic [RAM_AW-1:0] ram_adr,
  output logic [3:0]        ram_wren,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_adr,
  input  logic [31:0]       rom_rdata,
  output logic [7:0]        led,
  output logic              uart_tx
);

  localparam logic [31:0] RAM_SIZE = 32'd4 << RAM_AW;
  localparam logic [31:0] ROM_SIZE = 32'd4 << ROM_AW;

  state_e      state_reg;
  region_e     sel_reg;
  logic        rdy_reg;
  logic [31:0] io_rdata_reg;
  logic [7:0]  led_reg;
  logic        bus_err_reg;
  logic [31:0] cycles_reg;

  // Offsets wrap on subtraction, so a single unsigned compare covers both
  // the lower and upper bound of each region.
  logic [31:0] adr_w, ram_off, rom_off, io_off;
  region_e     region;
  logic        accept, is_write, uart_busy, uart_wr, uart_load;

  assign adr_w   = cpu_adr & ~32'h3;
  assign ram_off = adr_w - RAM_BASE;
  assign rom_off = adr_w - ROM_BASE;
  assign io_off  = adr_w - IO_BASE;

  always_comb begin
    region = REG_NONE;
    if (ram_off < RAM_SIZE)        region = REG_RAM;
    else if (rom_off < ROM_SIZE)   region = REG_ROM;
    else if (io_off < MM_IO_SIZE)  region = REG_IO;
  end

  assign accept   = (state_reg == IDLE) && cpu_mem_op;
  assign is_write = |cpu_wren;
  assign uart_wr  = accept && (region == REG_IO) && (io_off[3:0] == IO_UART) && cpu_wren[0];
  // A stalled UART write loads as soon as the transmitter frees up.
  assign uart_load = (uart_wr && !uart_busy) || ((state_reg == UART_STALL) && !uart_busy);

  // Memory strobes exist only in the acceptance cycle, so ACK never re-accesses.
  assign ram_en    = accept && (region == REG_RAM);
  assign ram_adr   = ram_off[RAM_AW+1:2];
  assign ram_wren  = ram_en ? cpu_wren : 4'b0000;
  assign ram_wdata = cpu_do;
  assign rom_en    = accept && (region == REG_ROM) && !is_write;
  assign rom_adr   = rom_off[ROM_AW+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      sel_reg      <= REG_NONE;
      rdy_reg      <= 1'b0;
      io_rdata_reg <= '0;
      led_reg      <= '0;
      bus_err_reg  <= 1'b0;
      cycles_reg   <= '0;
    end else begin
      cycles_reg <= cycles_reg + 32'd1;
      rdy_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cpu_mem_op) begin
            sel_reg      <= region;
            io_rdata_reg <= '0;
            state_reg    <= ACK;
            rdy_reg      <= 1'b1;
            case (region)
              REG_ROM:  if (is_write) bus_err_reg <= 1'b1;
              REG_NONE: bus_err_reg <= 1'b1;
              REG_IO: begin
                case (io_off[3:0])
                  IO_LED: begin
                    if (cpu_wren[0]) led_reg <= cpu_do[7:0];
                    io_rdata_reg <= {24'b0, led_reg};
                  end
                  IO_UART: begin
                    if (uart_wr && uart_busy) begin
                      state_reg <= UART_STALL;
                      rdy_reg   <= 1'b0;
                    end
                  end
                  IO_STATUS: begin
                    io_rdata_reg <= {30'b0, bus_err_reg, uart_busy};
                    if (is_write) bus_err_reg <= 1'b0;
                  end
                  IO_CYCLES: io_rdata_reg <= cycles_reg;
                  default: ;
                endcase
              end
              default: ;
            endcase
          end
        end
        UART_STALL: begin
          if (!uart_busy) begin
            state_reg <= ACK;
            rdy_reg   <= 1'b1;
          end
        end
        ACK:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // RAM/ROM data arrives the cycle after the strobe, i.e. during ACK.
  always_comb begin
    cpu_di = '0;
    if (rdy_reg) begin
      case (sel_reg)
        REG_RAM: cpu_di = ram_rdata;
        REG_ROM: cpu_di = rom_rdata;
        default: cpu_di = io_rdata_reg;
      endcase
    end
  end

  assign cpu_mem_rdy = rdy_reg;
  assign led         = led_reg;

  uart_tx_8n1 #(
    .CLK_DIV(CLK_DIV)
  ) u_uart (
    .clk   (clk),
    .reset (reset),
    .load  (uart_load),
    .data  (cpu_do[7:0]),
    .busy  (uart_busy),
    .tx    (uart_tx)
  );

endmodule
